mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access pipeline stage. Consumes the registered EX outputs (ctrl, ALU result, store data, dmem_info, destination register) and performs loads/stores over a req/ack data-memory port.
- Feeds a registered result bundle to write-back.
- Drives the stall (`mem_stall`) that upstream uses as its register lock while a memory transaction is outstanding.
- Bit 0 of every bus is the MSB. Memory is big-endian: byte lane 0 = data bits [0:7].

Parameters:
- TIMEOUT_CYCLES, 255, max WAIT cycles without dmem_ack before aborting. 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- ctrl  in  9  control word from EX. Bit 4 = mem_read, bit 5 = mem_write; all bits forwarded.
- alu_out  in  32  effective address / ALU result
- write_data  in  32  store data (rs2 value)
- dmem_info  in  3  [0:1] size: 00 byte, 01 half, 10 word, 11 treated as word. [2] 1 = zero-extend loads, 0 = sign-extend.
- write_reg  in  5  destination register
- mem_stall  out  1  combinational; 1 = upstream must hold its registers
- dmem_req  out  1  request valid, held until ack
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word-aligned address (alu_out with bits [30:31] = 0)
- dmem_be  out  4  byte enables, bit 0 = lane 0
- dmem_wdata  out  32  lane-replicated store data
- dmem_ack  in  1  transaction complete; read data valid this cycle
- dmem_rdata  in  32  read data
- ctrl_wb  out  9  registered ctrl
- result_wb  out  32  registered load data or ALU result
- write_reg_wb  out  5  registered destination
- mem_err  out  1  registered one-cycle pulse on misalign or timeout

Behaviour:
- mem_op = ctrl[4] | ctrl[5]. If both bits are set, treat as a write.
- Misaligned access: half with addr[31] = 1, or word with addr[30:31] ≠ 0.
- Reset (async): state IDLE, timeout counter 0, all registered outputs 0. dmem_req = 0 and mem_stall = 0 while rst is high.
- Reset mid-transaction: drop dmem_req immediately; nothing is written to the WB registers.

FSM states: IDLE, WAIT.

IDLE:
- Non-mem op: mem_stall = 0. Next edge loads ctrl_wb ← ctrl, result_wb ← alu_out, write_reg_wb ← write_reg. Latency 1.
- Aligned mem op: dmem_req = 1 (combinational) and mem_stall = 1. → WAIT, counter cleared. WB registers load a bubble (ctrl_wb = 0).
- Misaligned mem op: no request, mem_stall = 0. WB loads a bubble with ctrl_wb = 0 and mem_err = 1 for one cycle.

WAIT:
- dmem_req, dmem_we, dmem_addr, dmem_be and dmem_wdata stay driven and stable; inputs are held by the stall.
- dmem_ack is sampled only in WAIT, so minimum transaction latency is 2 cycles.
- While ack = 0: mem_stall = 1, counter increments, WB loads a bubble.
- ack = 1: mem_stall = 0. → IDLE. WB captures ctrl, write_reg, and result (extracted load data for a read, alu_out for a write).
- Timeout (counter = TIMEOUT_CYCLES, no ack): drop req, mem_stall = 0, → IDLE. WB captures ctrl with bits 4 and 5 cleared and result 0; mem_err pulses.
- Ack arriving on the timeout cycle: ack wins.

Store lanes:
- byte: wdata = {4{write_data[24:31]}}, be = one-hot on lane addr[30:31].
- half: wdata = {2{write_data[16:31]}}, be = 1100 if addr[30] = 0, else 0011.
- word: wdata = write_data, be = 1111.

Loads:
- dmem_be is set as for stores (read-enable lanes).
- byte = rdata lane addr[30:31]; half = rdata[0:15] if addr[30] = 0, else [16:31].
- Extend to 32 bits per dmem_info[2].

Other rules:
- All outputs other than mem_stall, dmem_req, dmem_we, dmem_addr, dmem_be and dmem_wdata are registered.
- dmem_req is never asserted in IDLE for a non-mem op.

Test Plan:
- Reset, then ALU op: ctrl = 9'b100000001, alu_out = 0x00000007, write_reg = 3 → next cycle ctrl_wb = 9'b100000001, result_wb = 7, write_reg_wb = 3; mem_stall never 1.
- lb signed at addr 0x00000102, ack after 3 WAIT cycles, rdata = 0x1122F344:
  - mem_stall high for 4 cycles; dmem_addr = 0x100, be = 0010.
  - Then result_wb = 0xFFFFFFF3; bubbles (ctrl_wb = 0) during the stall.
- sh at addr 0x00000206, write_data = 0xDEADBEEF, ack after 1 WAIT cycle → dmem_we = 1, wdata = 0xBEEFBEEF, be = 0011, addr = 0x204; result_wb = 0x206.
- lhu at addr 0x00000103 → no dmem_req, mem_err pulses once, ctrl_wb = 0, no stall.
- lw with no ack and TIMEOUT_CYCLES = 4 → mem_stall high exactly 5 cycles, then mem_err pulse, result_wb = 0, ctrl_wb bits 4 and 5 cleared.
- rst asserted during WAIT of a lw → dmem_req and mem_stall drop asynchronously, all WB outputs 0. After release, a back-to-back lw then sw both complete in order.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues loads/stores on a req/ack data port,
// stalls upstream while a transaction is outstanding, and registers the WB bundle.
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [0:8]  ctrl,
    input  logic [0:31] alu_out,
    input  logic [0:31] write_data,
    input  logic [0:2]  dmem_info,
    input  logic [0:4]  write_reg,
    output logic        mem_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [0:31] dmem_addr,
    output logic [0:3]  dmem_be,
    output logic [0:31] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [0:31] dmem_rdata,
    output logic [0:8]  ctrl_wb,
    output logic [0:31] result_wb,
    output logic [0:4]  write_reg_wb,
    output logic        mem_err
);

    // state | meaning
    // IDLE  | no transaction outstanding; non-mem ops pass straight to WB
    // WAIT  | request on the bus, waiting for dmem_ack or timeout
    typedef enum logic {IDLE, WAIT} state_t;

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT_CYCLES);

    state_t        state;
    logic [CW-1:0] wait_cnt;

    logic        mem_read;
    logic        mem_write;
    logic        mem_op;
    logic [1:0]  size;
    logic [1:0]  lane;
    logic        is_byte;
    logic        is_half;
    logic        is_word;
    logic        misalign;
    logic        start_ok;
    logic        timeout_hit;
    logic [0:7]  ld_byte;
    logic [0:15] ld_half;
    logic [0:31] ld_ext;
    logic [0:8]  ctrl_nomem;

    assign mem_read  = ctrl[4];
    assign mem_write = ctrl[5];
    assign mem_op    = mem_read | mem_write;
    assign size      = dmem_info[0:1];
    assign lane      = alu_out[30:31];
    assign is_byte   = (size == 2'b00);
    assign is_half   = (size == 2'b01);
    assign is_word   = size[1];
    assign misalign  = (is_half & alu_out[31]) | (is_word & (lane != 2'b00));
    assign start_ok  = mem_op & ~misalign;

    // Ack on the terminal-count cycle takes priority over the abort.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == TO_VAL) && !dmem_ack;

    always_comb begin
        ctrl_nomem    = ctrl;
        ctrl_nomem[4] = 1'b0;
        ctrl_nomem[5] = 1'b0;
    end

    always_comb begin
        dmem_req  = 1'b0;
        mem_stall = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    dmem_req  = start_ok;
                    mem_stall = start_ok;
                end
                WAIT: begin
                    dmem_req  = ~timeout_hit;
                    mem_stall = ~dmem_ack & ~timeout_hit;
                end
                default: ;
            endcase
        end
    end

    assign dmem_we   = dmem_req & mem_write;
    assign dmem_addr = {alu_out[0:29], 2'b00};

    always_comb begin
        dmem_be    = 4'b1111;
        dmem_wdata = write_data;
        if (is_byte) begin
            dmem_wdata = {4{write_data[24:31]}};
            case (lane)
                2'd0:    dmem_be = 4'b1000;
                2'd1:    dmem_be = 4'b0100;
                2'd2:    dmem_be = 4'b0010;
                default: dmem_be = 4'b0001;
            endcase
        end else if (is_half) begin
            dmem_wdata = {2{write_data[16:31]}};
            dmem_be    = alu_out[30] ? 4'b0011 : 4'b1100;
        end
    end

    always_comb begin
        case (lane)
            2'd0:    ld_byte = dmem_rdata[0:7];
            2'd1:    ld_byte = dmem_rdata[8:15];
            2'd2:    ld_byte = dmem_rdata[16:23];
            default: ld_byte = dmem_rdata[24:31];
        endcase
        ld_half = alu_out[30] ? dmem_rdata[16:31] : dmem_rdata[0:15];
        if (is_byte)
            ld_ext = {{24{~dmem_info[2] & ld_byte[0]}}, ld_byte};
        else if (is_half)
            ld_ext = {{16{~dmem_info[2] & ld_half[0]}}, ld_half};
        else
            ld_ext = dmem_rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            ctrl_wb      <= '0;
            result_wb    <= '0;
            write_reg_wb <= '0;
            mem_err      <= 1'b0;
        end else begin
            ctrl_wb      <= '0;
            result_wb    <= '0;
            write_reg_wb <= '0;
            mem_err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        state    <= WAIT;
                        wait_cnt <= '0;
                    end else if (mem_op) begin
                        mem_err <= 1'b1;
                    end else begin
                        ctrl_wb      <= ctrl;
                        result_wb    <= alu_out;
                        write_reg_wb <= write_reg;
                    end
                end
                WAIT: begin
                    if (dmem_ack) begin
                        state        <= IDLE;
                        ctrl_wb      <= ctrl;
                        result_wb    <= mem_write ? alu_out : ld_ext;
                        write_reg_wb <= write_reg;
                    end else if (timeout_hit) begin
                        state        <= IDLE;
                        ctrl_wb      <= ctrl_nomem;
                        write_reg_wb <= write_reg;
                        mem_err      <= 1'b1;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage with a short timeout.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic [0:8]  ctrl;
    logic [0:31] alu_out;
    logic [0:31] write_data;
    logic [0:2]  dmem_info;
    logic [0:4]  write_reg;
    logic        mem_stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [0:31] dmem_addr;
    logic [0:3]  dmem_be;
    logic [0:31] dmem_wdata;
    logic        dmem_ack;
    logic [0:31] dmem_rdata;
    logic [0:8]  ctrl_wb;
    logic [0:31] result_wb;
    logic [0:4]  write_reg_wb;
    logic        mem_err;

    int checks = 0;
    int errors = 0;
    int stall_cnt = 0;
    int s0;

    mem_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .ctrl(ctrl), .alu_out(alu_out),
        .write_data(write_data), .dmem_info(dmem_info), .write_reg(write_reg),
        .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .ctrl_wb(ctrl_wb),
        .result_wb(result_wb), .write_reg_wb(write_reg_wb), .mem_err(mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (mem_stall) stall_cnt = stall_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [0:8] c, input logic [0:31] a, input logic [0:31] wd,
                          input logic [0:2] info, input logic [0:4] wr);
        ctrl       = c;
        alu_out    = a;
        write_data = wd;
        dmem_info  = info;
        write_reg  = wr;
    endtask

    initial begin
        rst = 1'b1;
        dmem_ack = 1'b0;
        dmem_rdata = '0;
        set_op(9'b0, 32'h0, 32'h0, 3'b000, 5'd0);
        tick();
        tick();
        chk("reset_req", 32'(dmem_req), 32'h0);
        chk("reset_stall", 32'(mem_stall), 32'h0);
        chk("reset_ctrl_wb", 32'(ctrl_wb), 32'h0);
        chk("reset_result_wb", result_wb, 32'h0);
        chk("reset_err", 32'(mem_err), 32'h0);
        rst = 1'b0;

        // ALU pass-through
        set_op(9'b100000001, 32'h7, 32'h0, 3'b000, 5'd3);
        #1;
        chk("alu_stall", 32'(mem_stall), 32'h0);
        chk("alu_req", 32'(dmem_req), 32'h0);
        tick();
        chk("alu_ctrl_wb", 32'(ctrl_wb), 32'(9'b100000001));
        chk("alu_result_wb", result_wb, 32'h7);
        chk("alu_wreg_wb", 32'(write_reg_wb), 32'd3);

        // lb signed at 0x102, ack on 4th WAIT cycle
        s0 = stall_cnt;
        set_op(9'b000010000, 32'h102, 32'h0, 3'b000, 5'd5);
        #1;
        chk("lb_req", 32'(dmem_req), 32'h1);
        chk("lb_we", 32'(dmem_we), 32'h0);
        chk("lb_addr", dmem_addr, 32'h100);
        chk("lb_be", 32'(dmem_be), 32'b0010);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("lb_bubble", 32'(ctrl_wb), 32'h0);
            chk("lb_wait_stall", 32'(mem_stall), 32'h1);
            chk("lb_wait_addr", dmem_addr, 32'h100);
        end
        tick();
        dmem_ack = 1'b1;
        dmem_rdata = 32'h1122F344;
        #1;
        chk("lb_ack_stall", 32'(mem_stall), 32'h0);
        chk("lb_ack_req", 32'(dmem_req), 32'h1);
        tick();
        dmem_ack = 1'b0;
        chk("lb_result", result_wb, 32'hFFFFFFF3);
        chk("lb_ctrl_wb", 32'(ctrl_wb), 32'(9'b000010000));
        chk("lb_wreg_wb", 32'(write_reg_wb), 32'd5);
        chk("lb_stall_cycles", 32'(stall_cnt - s0), 32'd4);

        // sh at 0x206, ack after one WAIT cycle
        s0 = stall_cnt;
        set_op(9'b000001000, 32'h206, 32'hDEADBEEF, 3'b010, 5'd0);
        #1;
        chk("sh_we", 32'(dmem_we), 32'h1);
        chk("sh_wdata", dmem_wdata, 32'hBEEFBEEF);
        chk("sh_be", 32'(dmem_be), 32'b0011);
        chk("sh_addr", dmem_addr, 32'h204);
        tick();
        chk("sh_wait_stall", 32'(mem_stall), 32'h1);
        tick();
        dmem_ack = 1'b1;
        #1;
        chk("sh_ack_stall", 32'(mem_stall), 32'h0);
        tick();
        dmem_ack = 1'b0;
        chk("sh_result", result_wb, 32'h206);
        chk("sh_ctrl_wb", 32'(ctrl_wb), 32'(9'b000001000));
        chk("sh_stall_cycles", 32'(stall_cnt - s0), 32'd2);

        // lhu misaligned at 0x103
        s0 = stall_cnt;
        set_op(9'b000010000, 32'h103, 32'h0, 3'b011, 5'd6);
        #1;
        chk("mis_req", 32'(dmem_req), 32'h0);
        chk("mis_stall", 32'(mem_stall), 32'h0);
        tick();
        chk("mis_err", 32'(mem_err), 32'h1);
        chk("mis_ctrl_wb", 32'(ctrl_wb), 32'h0);
        set_op(9'b100000000, 32'h55, 32'h0, 3'b000, 5'd1);
        tick();
        chk("mis_err_once", 32'(mem_err), 32'h0);
        chk("mis_no_stall", 32'(stall_cnt - s0), 32'd0);

        // sb lane 1 byte replication
        set_op(9'b000001000, 32'h301, 32'h000000A5, 3'b001, 5'd0);
        #1;
        chk("sb_wdata", dmem_wdata, 32'hA5A5A5A5);
        chk("sb_be", 32'(dmem_be), 32'b0100);
        tick();
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        chk("sb_result", result_wb, 32'h301);

        // lw with no ack: times out
        s0 = stall_cnt;
        set_op(9'b110010000, 32'h40, 32'h0, 3'b100, 5'd9);
        begin
            int n;
            n = 0;
            #1;
            while (mem_stall && n < 20) begin
                tick();
                n = n + 1;
            end
            chk("to_bounded", 32'(n), 32'd5);
        end
        chk("to_req_drop", 32'(dmem_req), 32'h0);
        tick();
        chk("to_err", 32'(mem_err), 32'h1);
        chk("to_result", result_wb, 32'h0);
        chk("to_ctrl_wb", 32'(ctrl_wb), 32'(9'b110000000));
        chk("to_stall_cycles", 32'(stall_cnt - s0), 32'd5);
        set_op(9'b100000000, 32'h0, 32'h0, 3'b000, 5'd0);
        tick();
        chk("to_err_once", 32'(mem_err), 32'h0);

        // lbu with ack on the timeout cycle: ack wins
        set_op(9'b000010000, 32'h301, 32'h0, 3'b001, 5'd4);
        for (int i = 0; i < 5; i++) tick();
        dmem_ack = 1'b1;
        dmem_rdata = 32'h00AB0000;
        #1;
        chk("tack_stall", 32'(mem_stall), 32'h0);
        chk("tack_req", 32'(dmem_req), 32'h1);
        tick();
        dmem_ack = 1'b0;
        chk("tack_result", result_wb, 32'h000000AB);
        chk("tack_err", 32'(mem_err), 32'h0);
        chk("tack_ctrl_wb", 32'(ctrl_wb), 32'(9'b000010000));

        // reset during WAIT
        set_op(9'b000010000, 32'h80, 32'h0, 3'b100, 5'd7);
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("rst_req", 32'(dmem_req), 32'h0);
        chk("rst_stall", 32'(mem_stall), 32'h0);
        chk("rst_ctrl_wb", 32'(ctrl_wb), 32'h0);
        chk("rst_result_wb", result_wb, 32'h0);
        chk("rst_wreg_wb", 32'(write_reg_wb), 32'h0);
        tick();
        rst = 1'b0;

        // back-to-back lw then sw
        set_op(9'b000010000, 32'h10, 32'h0, 3'b100, 5'd8);
        #1;
        chk("b2b_lw_req", 32'(dmem_req), 32'h1);
        tick();
        dmem_ack = 1'b1;
        dmem_rdata = 32'hCAFEF00D;
        tick();
        chk("b2b_lw_result", result_wb, 32'hCAFEF00D);
        chk("b2b_lw_wreg", 32'(write_reg_wb), 32'd8);
        dmem_ack = 1'b0;
        set_op(9'b000001000, 32'h14, 32'h12345678, 3'b100, 5'd0);
        #1;
        chk("b2b_sw_we", 32'(dmem_we), 32'h1);
        chk("b2b_sw_wdata", dmem_wdata, 32'h12345678);
        tick();
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        chk("b2b_sw_result", result_wb, 32'h14);
        chk("b2b_sw_ctrl", 32'(ctrl_wb), 32'(9'b000001000));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
